fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Consumer end of the next-PC path: owns the PC register, fetches instructions from instruction memory over a valid/ready request + valid response interface, and drives the F/D pipeline register.
- Sends the current fetch PC and the decode-stage PC (PC_D) to the next-PC logic, and loads the returned NPC when decode advances.
- Sits between the next-PC logic, the hazard unit (stall in, fetch_wait out) and the instruction memory.

Parameters:
- RESET_PC, 32'h0000_3000, PC value after reset.
- NOP_INSTR, 32'h0000_0000, IR_D value after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; asserted (0) clears all state immediately.
- NPC  in  32  next fetch PC from the next-PC logic; combinational from PC/PC_D.
- stall  in  1  hazard-unit freeze of the F/D register.
- PC  out  32  current fetch PC.
- PC_D  out  32  PC of the instruction held in decode.
- IR_D  out  32  instruction held in decode.
- fetch_wait  out  1  decode cannot advance because fetch has no instruction ready; the hazard unit inserts a bubble into E.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_addr  out  32  request address; always equals PC.
- imem_rsp_valid  in  1  response data valid; pulse of one cycle per accepted request.
- imem_rsp_data  in  32  instruction word.

Behaviour:
- Reset values:
  - PC = RESET_PC; PC_D = RESET_PC; IR_D = NOP_INSTR.
  - state = REQ; hold buffer = 0.
- States:
  - REQ: imem_req_valid = 1, imem_addr = PC.
    - req_ready = 1 → WAIT.
    - Otherwise stay in REQ; valid and addr held stable.
  - WAIT: no request.
    - rsp_valid & !stall → advance with rsp_data → REQ.
    - rsp_valid & stall → capture rsp_data in the hold buffer → HOLD.
    - Otherwise stay in WAIT.
  - HOLD: no request.
    - !stall → advance with the hold buffer → REQ.
- Advance (one clock edge):
  - IR_D ← instruction word.
  - PC_D ← PC.
  - PC ← NPC.
  - NPC is sampled in the same cycle, so it reflects the instruction currently in D (delay-slot semantics preserved).
- F/D register and PC change only on advance. stall always wins: no update while stall = 1, in any state.
- fetch_wait = !advance & !stall. It is combinational and is 0 during reset.
- At most one outstanding request. imem_rsp_valid is ignored in REQ and HOLD; this also drops a stale response that arrives after a reset taken mid-request.
- Throughput: with 1-cycle memory and no stall, one instruction per 2 cycles (REQ, WAIT). No speculative next-PC request.
- NPC is taken verbatim: no alignment masking; PC wraps modulo 2^32.
- stall asserted in REQ does not block the request from issuing; only the advance is blocked.
- Reset asserted in any state returns to REQ on deassertion, with PC = RESET_PC.

Decomposition:
- Shared package holds:
  - RESET_PC and NOP_INSTR defaults.
  - State encoding localparams FS_REQ = 2'd0, FS_WAIT = 2'd1, FS_HOLD = 2'd2.
- One natural sub-module: fd_reg, the F/D pipeline register with enable and async active-low reset.
- The FSM, PC register and hold buffer stay in fetch_unit.

Test Plan:
1. Reset release; ready = 1; 1-cycle response 0x2402_0005; NPC = PC+4.
   - Req at addr 0x3000.
   - After the response edge: IR_D = 0x2402_0005, PC_D = 0x3000, PC = 0x3004.
   - Next req at 0x3004.
2. ready held low 3 cycles at PC 0x3008.
   - req_valid stays 1 and addr stays 0x3008.
   - fetch_wait = 1 every cycle.
   - PC, PC_D, IR_D unchanged.
3. Response 0x1000_0003 arrives with stall = 1 for 2 cycles.
   - Enter HOLD; fetch_wait = 0; no new request.
   - Cycle after stall drops: IR_D = 0x1000_0003.
4. Branch in D: NPC = 0x3040 while delay-slot word 0x0000_0000 returns from PC 0x3014.
   - After advance: PC_D = 0x3014, PC = 0x3040.
   - Next req at 0x3040.
5. Reset pulled low in WAIT; the response arrives the first cycle after release.
   - Response ignored; PC = 0x3000; IR_D = 0.
   - New req at 0x3000.
6. NPC = 0xFFFF_FFFC, then NPC = PC+4.
   - PC = 0xFFFF_FFFC, then wraps to 0x0000_0000.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch unit: reset defaults, FSM encoding and F/D payload.
package fetch_unit_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT  = 32'h0000_3000;
  localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

  localparam logic [1:0] FS_REQ  = 2'd0;
  localparam logic [1:0] FS_WAIT = 2'd1;
  localparam logic [1:0] FS_HOLD = 2'd2;

  typedef enum logic [1:0] {
    ST_REQ  = FS_REQ,
    ST_WAIT = FS_WAIT,
    ST_HOLD = FS_HOLD
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] ir;
  } fd_payload_t;

endpackage : fetch_unit_pkg

// File: rtl/fetch_unit_fd_reg.sv
// F/D pipeline register: loads PC/instruction pair when enabled, async active-low reset.
module fd_reg
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_en,
  input  fd_payload_t i_d,
  output fd_payload_t o_q
);

  fd_payload_t r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q.pc <= RESET_PC;
      r_q.ir <= NOP_INSTR;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule : fd_reg

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, runs a single-outstanding imem request/response FSM
// and advances the F/D register when an instruction is ready and decode is not stalled.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] NPC,
  input  logic            stall,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PC_D,
  output logic [XLEN-1:0] IR_D,
  output logic            fetch_wait,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data
);

  fetch_state_e    r_state;
  fetch_state_e    w_next_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_hold;
  logic [XLEN-1:0] w_instr;
  logic            w_advance;
  logic            w_capture;
  logic            w_req_valid;
  fd_payload_t     w_fd_d;
  fd_payload_t     w_fd_q;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_REQ;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state; responses outside WAIT are dropped, stall always blocks the advance
  always_comb begin
    w_next_state = r_state;
    w_advance    = 1'b0;
    w_capture    = 1'b0;
    w_req_valid  = 1'b0;
    w_instr      = r_hold;
    case (r_state)
      ST_REQ: begin
        w_req_valid = 1'b1;
        if (imem_req_ready) begin
          w_next_state = ST_WAIT;
        end
      end
      ST_WAIT: begin
        w_instr = imem_rsp_data;
        if (imem_rsp_valid) begin
          if (stall) begin
            w_capture    = 1'b1;
            w_next_state = ST_HOLD;
          end else begin
            w_advance    = 1'b1;
            w_next_state = ST_REQ;
          end
        end
      end
      ST_HOLD: begin
        if (!stall) begin
          w_advance    = 1'b1;
          w_next_state = ST_REQ;
        end
      end
      default: w_next_state = ST_REQ;
    endcase
  end

  // PC and hold buffer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc   <= RESET_PC;
      r_hold <= '0;
    end else begin
      if (w_advance) begin
        r_pc <= NPC;
      end
      if (w_capture) begin
        r_hold <= imem_rsp_data;
      end
    end
  end

  assign w_fd_d.pc = r_pc;
  assign w_fd_d.ir = w_instr;

  fd_reg #(
    .RESET_PC  (RESET_PC),
    .NOP_INSTR (NOP_INSTR)
  ) u_fd_reg (
    .clk   (clk),
    .rst_n (reset),
    .i_en  (w_advance),
    .i_d   (w_fd_d),
    .o_q   (w_fd_q)
  );

  assign PC             = r_pc;
  assign PC_D           = w_fd_q.pc;
  assign IR_D           = w_fd_q.ir;
  assign imem_req_valid = w_req_valid;
  assign imem_addr      = r_pc;
  // Held low in reset so the hazard unit sees no bubble request
  assign fetch_wait     = reset & ~w_advance & ~stall;

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: each accepted imem request is checked against
// the expected address and F/D state queued by the directed stimulus.
module tb_fetch_unit;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] pc;
    logic [31:0] pc_d;
    logic [31:0] ir_d;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [31:0] NPC;
  logic        stall;
  logic [31:0] PC;
  logic [31:0] PC_D;
  logic [31:0] IR_D;
  logic        fetch_wait;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;

  logic        npc_ovr_en;
  logic [31:0] npc_ovr;

  exp_t exp_q[$];
  int   n_tests;
  int   n_fail;

  fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .NPC            (NPC),
    .stall          (stall),
    .PC             (PC),
    .PC_D           (PC_D),
    .IR_D           (IR_D),
    .fetch_wait     (fetch_wait),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data)
  );

  // Next-PC logic stand-in: sequential unless a redirect is forced
  assign NPC = npc_ovr_en ? npc_ovr : PC + 32'd4;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] addr, input logic [31:0] pc,
                      input logic [31:0] pc_d, input logic [31:0] ir_d);
    exp_t e;
    e.addr = addr;
    e.pc   = pc;
    e.pc_d = pc_d;
    e.ir_d = ir_d;
    exp_q.push_back(e);
  endtask

  task automatic respond(input logic [31:0] data);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    tick();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'hxxxx_xxxx;
  endtask

  // Monitor: every request the memory accepts must match the next scoreboard entry
  always @(negedge clk) begin
    if (reset && imem_req_valid && imem_req_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected_req: got addr 0x%08h expected no request", imem_addr);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_addr", imem_addr, e.addr);
        check("sb_pc",   PC,        e.pc);
        check("sb_pc_d", PC_D,      e.pc_d);
        check("sb_ir_d", IR_D,      e.ir_d);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_tests        = 0;
    n_fail         = 0;
    reset          = 1'b0;
    stall          = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    npc_ovr_en     = 1'b0;
    npc_ovr        = 32'h0;
    repeat (2) tick();

    check("rst_pc",         PC,                3'h0 + 32'h0000_3000);
    check("rst_pc_d",       PC_D,              32'h0000_3000);
    check("rst_ir_d",       IR_D,              32'h0000_0000);
    check("rst_fetch_wait", 32'(fetch_wait),   32'd0);

    // 1: first fetch, 1-cycle response
    reset = 1'b1;
    push(32'h3000, 32'h3000, 32'h3000, 32'h0);
    imem_req_ready = 1'b1;
    tick();
    push(32'h3004, 32'h3004, 32'h3000, 32'h2402_0005);
    respond(32'h2402_0005);
    check("t1_ir_d", IR_D, 32'h2402_0005);
    check("t1_pc",   PC,   32'h3004);
    tick();
    imem_req_ready = 1'b0;
    respond(32'h2403_000a);

    // 2: memory not ready for 3 cycles at 0x3008
    for (int i = 0; i < 3; i++) begin
      check("t2_req_valid",  32'(imem_req_valid), 32'd1);
      check("t2_addr",       imem_addr,           32'h3008);
      check("t2_fetch_wait", 32'(fetch_wait),     32'd1);
      check("t2_pc",         PC,                  32'h3008);
      check("t2_pc_d",       PC_D,                32'h3004);
      check("t2_ir_d",       IR_D,                32'h2403_000a);
      tick();
    end
    push(32'h3008, 32'h3008, 32'h3004, 32'h2403_000a);
    imem_req_ready = 1'b1;
    tick();

    // 3: response lands under stall, parked in HOLD for 2 cycles
    stall = 1'b1;
    respond(32'h1000_0003);
    for (int i = 0; i < 2; i++) begin
      check("t3_fetch_wait", 32'(fetch_wait),     32'd0);
      check("t3_req_valid",  32'(imem_req_valid), 32'd0);
      check("t3_ir_d",       IR_D,                32'h2403_000a);
      if (i == 0) tick();
    end
    push(32'h300c, 32'h300c, 32'h3008, 32'h1000_0003);
    stall = 1'b0;
    tick();
    check("t3_ir_d_adv", IR_D, 32'h1000_0003);

    // 4: branch in D redirects after its delay slot
    tick();
    push(32'h3010, 32'h3010, 32'h300c, 32'h8c08_0000);
    respond(32'h8c08_0000);
    tick();
    push(32'h3014, 32'h3014, 32'h3010, 32'h1000_000b);
    respond(32'h1000_000b);
    tick();
    npc_ovr_en = 1'b1;
    npc_ovr    = 32'h3040;
    push(32'h3040, 32'h3040, 32'h3014, 32'h0);
    respond(32'h0000_0000);
    npc_ovr_en = 1'b0;
    check("t4_pc_d", PC_D, 32'h3014);
    check("t4_pc",   PC,   32'h3040);
    tick();

    // 5: reset mid-WAIT, stale response right after release
    reset          = 1'b0;
    imem_req_ready = 1'b0;
    #1;
    check("t5_rst_fetch_wait", 32'(fetch_wait), 32'd0);
    check("t5_rst_pc",         PC,              32'h3000);
    tick();
    reset          = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hdead_beef;
    tick();
    imem_rsp_valid = 1'b0;
    check("t5_ir_d",      IR_D,                32'h0);
    check("t5_pc",        PC,                  32'h3000);
    check("t5_req_valid", 32'(imem_req_valid), 32'd1);
    check("t5_addr",      imem_addr,           32'h3000);
    push(32'h3000, 32'h3000, 32'h3000, 32'h0);
    imem_req_ready = 1'b1;
    tick();

    // 6: PC wraps past 0xFFFF_FFFC; stall in REQ still lets the request out
    npc_ovr_en = 1'b1;
    npc_ovr    = 32'hffff_fffc;
    push(32'hffff_fffc, 32'hffff_fffc, 32'h3000, 32'h1111_1111);
    respond(32'h1111_1111);
    npc_ovr_en = 1'b0;
    check("t6_pc_top", PC, 32'hffff_fffc);
    stall = 1'b1;
    tick();
    check("t6_stall_req_sent", 32'(imem_req_valid), 32'd0);
    check("t6_stall_fw",       32'(fetch_wait),     32'd0);
    stall = 1'b0;
    push(32'h0, 32'h0, 32'hffff_fffc, 32'h2222_2222);
    respond(32'h2222_2222);
    check("t6_pc_wrap", PC, 32'h0);
    tick();
    imem_req_ready = 1'b0;
    repeat (3) tick();

    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_fetch_unit
